// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: pong match state machine with BCD scores, ball count, serve side, pause, winner and frame-tick delay timer
module pong_match_ctrl #(
    parameter int BALLS       = 3,
    parameter int WIN_SCORE   = 11,
    parameter int DELAY_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [1:0] btnA,
    input  logic [1:0] btnB,
    input  logic       pause_req,
    input  logic       hit_A,
    input  logic       hit_B,
    input  logic       miss_A,
    input  logic       miss_B,
    output logic [2:0] state,
    output logic       gra_still,
    output logic [7:0] balls_left,
    output logic [3:0] dig0_A,
    output logic [3:0] dig1_A,
    output logic [3:0] dig0_B,
    output logic [3:0] dig1_B,
    output logic       serve_side,
    output logic [1:0] winner,
    output logic       timer_up
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PLAY    = 3'd1;
    localparam logic [2:0] S_NEWBALL = 3'd2;
    localparam logic [2:0] S_OVER    = 3'd3;
    localparam logic [2:0] S_PAUSE   = 3'd4;
    localparam logic [7:0] WIN_BCD    = 8'(((WIN_SCORE / 10) << 4) | (WIN_SCORE % 10));
    localparam logic [7:0] BALLS_INIT = 8'(BALLS);
    localparam logic [9:0] DELAY      = 10'(DELAY_TICKS);
    localparam logic       WIN_EN     = (WIN_SCORE != 0);

    logic [2:0] state_q, state_d;
    logic [7:0] a_q, a_d, b_q, b_d, balls_q, balls_d;
    logic [9:0] timer_q, timer_d;
    logic       serve_q, serve_d;
    logic [1:0] winner_q, winner_d;
    logic       load, press, a_win, b_win;
    logic [7:0] a_inc, b_inc;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v == 8'h99) ? v : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign press = (btnA != 2'b00) || (btnB != 2'b00);
    assign a_inc = hit_A ? bcd_inc(a_q) : a_q;
    assign b_inc = hit_B ? bcd_inc(b_q) : b_q;
    assign a_win = WIN_EN && (a_inc == WIN_BCD);
    assign b_win = WIN_EN && (b_inc == WIN_BCD);

    // state and datapath registers, synchronous reset to the idle match
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            balls_q  <= BALLS_INIT;
            serve_q  <= 1'b0;
            winner_q <= 2'b00;
            timer_q  <= 10'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            balls_q  <= balls_d;
            serve_q  <= serve_d;
            winner_q <= winner_d;
            timer_q  <= timer_d;
        end
    end

    // next state plus score, ball, serve and winner updates; win takes priority over a miss
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        balls_d  = balls_q;
        serve_d  = serve_q;
        winner_d = winner_q;
        load     = 1'b0;
        case (state_q)
            S_IDLE: begin
                a_d      = 8'h00;
                b_d      = 8'h00;
                balls_d  = BALLS_INIT;
                winner_d = 2'b00;
                if (press) state_d = S_PLAY;
            end
            S_PLAY: begin
                a_d = a_inc;
                b_d = b_inc;
                if (a_win || b_win) begin
                    winner_d = {b_win, a_win};
                    load     = 1'b1;
                    state_d  = S_OVER;
                end else if (miss_A || miss_B) begin
                    balls_d = balls_q - 8'd1;
                    serve_d = ~miss_A;
                    load    = 1'b1;
                    if (balls_q == 8'd1) begin
                        state_d  = S_OVER;
                        winner_d = (a_inc > b_inc) ? 2'b01 : (b_inc > a_inc) ? 2'b10 : 2'b11;
                    end else begin
                        state_d = S_NEWBALL;
                    end
                end else if (pause_req) begin
                    state_d = S_PAUSE;
                end
            end
            S_NEWBALL: if (timer_up && press) state_d = S_PLAY;
            S_PAUSE:   if (pause_req) state_d = S_PLAY;
            S_OVER: begin
                if (timer_up) begin
                    state_d  = S_IDLE;
                    a_d      = 8'h00;
                    b_d      = 8'h00;
                    balls_d  = BALLS_INIT;
                    winner_d = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // delay timer: load wins over a coincident frame tick; frozen while paused
    always_comb begin
        timer_d = load ? DELAY
                : (frame_tick && timer_q != 10'd0 && state_q != S_PAUSE) ? timer_q - 10'd1
                : timer_q;
    end

    // outputs decoded from registered state only
    always_comb begin
        state      = state_q;
        gra_still  = (state_q != S_PLAY);
        balls_left = balls_q;
        dig0_A     = a_q[3:0];
        dig1_A     = a_q[7:4];
        dig0_B     = b_q[3:0];
        dig1_B     = b_q[7:4];
        serve_side = serve_q;
        winner     = winner_q;
        timer_up   = (timer_q == 10'd0);
    end
endmodule
